rvv_backend_alu_mask_viota_seq: RTL and testbench



---
 rtl/rvv_pkg.sv | 29 ++
 rtl/rvv_backend_alu_unit_mask_viota32.sv | 19 +
 rtl/rvv_backend_alu_mask_viota_seq.sv | 187 ++++++++++++++++++
 tb/tb_rvv_backend_alu_mask_viota_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rvv_pkg.sv
// Shared RVV backend definitions: register geometry, SEW encoding and
// per-uop element count helper.
package rvv_pkg;

  localparam int VLEN = 256;
  localparam int VLW  = $clog2(VLEN) + 1;

  typedef enum logic [1:0] {
    SEW_8    = 2'b00,
    SEW_16   = 2'b01,
    SEW_32   = 2'b10,
    SEW_RSVD = 2'b11
  } sew_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } seq_state_e;

  // The reserved encoding behaves as SEW=32.
  function automatic logic [5:0] elems_per_uop(input sew_e sew);
    case (sew)
      SEW_8:   return 6'(VLEN / 8);
      SEW_16:  return 6'(VLEN / 16);
      default: return 6'(VLEN / 32);
    endcase
  endfunction

endpackage

// File: rtl/rvv_backend_alu_unit_mask_viota32.sv
// Exclusive prefix popcount over 32 mask bits: prefix[i] = number of set
// bits strictly below bit i, packed 6 bits per element.
module rvv_backend_alu_unit_mask_viota32 (
  input  logic [31:0]  i_mask,
  output logic [191:0] o_prefix
);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_prefix
      if (gi == 0) begin : g_first
        assign o_prefix[5:0] = 6'd0;
      end else begin : g_rest
        assign o_prefix[gi*6 +: 6] = 6'($countones(i_mask[gi-1:0]));
      end
    end
  endgenerate

endmodule

// File: rtl/rvv_backend_alu_mask_viota_seq.sv
// Sequential viota.m stage: adds a running count carried across the uops of
// one instruction to per-uop prefix counts and packs SEW-wide results.
module rvv_backend_alu_mask_viota_seq
  import rvv_pkg::*;
#(
  parameter int VLEN = rvv_pkg::VLEN,
  parameter int VLW  = $clog2(VLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_uop_index,
  input  logic            in_uop_last,
  input  logic [1:0]      in_sew,
  input  logic [VLW-1:0]  in_vl,
  input  logic            in_vm,
  input  logic [31:0]     in_vs2_mask,
  input  logic [31:0]     in_v0_mask,
  input  logic [VLEN-1:0] in_vd_old,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [VLEN-1:0] out_vd,
  output logic [2:0]      out_uop_index,
  output logic            out_last,
  output logic            seq_err
);

  localparam int E8  = VLEN / 8;
  localparam int E16 = VLEN / 16;
  localparam int E32 = VLEN / 32;

  seq_state_e      r_state;
  seq_state_e      w_state_next;
  logic [VLW-1:0]  r_carry;
  logic [VLW-1:0]  w_carry_next;
  logic [2:0]      r_exp_idx;
  logic [2:0]      w_exp_idx_next;

  logic            r_out_valid;
  logic [VLEN-1:0] r_out_vd;
  logic [2:0]      r_out_uop_index;
  logic            r_out_last;
  logic            r_seq_err;

  sew_e            w_sew;
  logic [5:0]      w_elems;
  logic            w_accept;
  logic [VLW-1:0]  w_base;
  logic [VLW-1:0]  w_carry_in;
  logic            w_seq_mismatch;
  logic [31:0]     w_active;
  logic [31:0]     w_eff;
  logic [191:0]    w_prefix;
  logic [VLW-1:0]  w_elem_cnt [32];
  logic [VLW-1:0]  w_popcnt;
  logic [VLEN-1:0] w_vd8;
  logic [VLEN-1:0] w_vd16;
  logic [VLEN-1:0] w_vd32;
  logic [VLEN-1:0] w_vd;

  assign w_sew    = sew_e'(in_sew);
  assign w_elems  = elems_per_uop(w_sew);
  assign in_ready = !flush && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_base   = VLW'(in_uop_index) * VLW'(w_elems);

  // An instruction always starts from zero, even if its first uop is misnumbered.
  assign w_carry_in = (r_state == ST_ACTIVE) ? r_carry : '0;
  assign w_seq_mismatch = (r_state == ST_IDLE) ? (in_uop_index != 3'd0)
                                               : (in_uop_index != r_exp_idx);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_elem
      logic [VLW-1:0] w_gidx;
      assign w_gidx        = w_base + VLW'(gi);
      assign w_active[gi]  = (6'(gi) < w_elems) && (w_gidx < in_vl) &&
                             (in_vm || in_v0_mask[gi]);
      assign w_eff[gi]     = in_vs2_mask[gi] & w_active[gi];
      assign w_elem_cnt[gi] = w_carry_in + VLW'(w_prefix[gi*6 +: 6]);
    end
  endgenerate

  rvv_backend_alu_unit_mask_viota32 u_viota32 (
    .i_mask   (w_eff),
    .o_prefix (w_prefix)
  );

  // Total of this uop = exclusive prefix of the last element plus its own bit.
  always_comb begin
    w_popcnt = '0;
    case (w_sew)
      SEW_8:   w_popcnt = VLW'(w_prefix[(E8-1)*6 +: 6])  + VLW'(w_eff[E8-1]);
      SEW_16:  w_popcnt = VLW'(w_prefix[(E16-1)*6 +: 6]) + VLW'(w_eff[E16-1]);
      default: w_popcnt = VLW'(w_prefix[(E32-1)*6 +: 6]) + VLW'(w_eff[E32-1]);
    endcase
  end

  generate
    for (gi = 0; gi < E8; gi++) begin : g_pack8
      assign w_vd8[gi*8 +: 8] = w_active[gi] ? w_elem_cnt[gi][7:0]
                                             : in_vd_old[gi*8 +: 8];
    end
    for (gi = 0; gi < E16; gi++) begin : g_pack16
      assign w_vd16[gi*16 +: 16] = w_active[gi] ? 16'(w_elem_cnt[gi])
                                                : in_vd_old[gi*16 +: 16];
    end
    for (gi = 0; gi < E32; gi++) begin : g_pack32
      assign w_vd32[gi*32 +: 32] = w_active[gi] ? 32'(w_elem_cnt[gi])
                                                : in_vd_old[gi*32 +: 32];
    end
  endgenerate

  always_comb begin
    w_vd = w_vd32;
    case (w_sew)
      SEW_8:   w_vd = w_vd8;
      SEW_16:  w_vd = w_vd16;
      default: w_vd = w_vd32;
    endcase
  end

  always_comb begin
    w_state_next   = r_state;
    w_carry_next   = r_carry;
    w_exp_idx_next = r_exp_idx;
    if (flush) begin
      w_state_next   = ST_IDLE;
      w_carry_next   = '0;
      w_exp_idx_next = '0;
    end else if (w_accept) begin
      if (in_uop_last) begin
        w_state_next   = ST_IDLE;
        w_carry_next   = '0;
        w_exp_idx_next = '0;
      end else begin
        w_state_next   = ST_ACTIVE;
        w_carry_next   = w_carry_in + w_popcnt;
        w_exp_idx_next = in_uop_index + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_carry   <= '0;
      r_exp_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_carry   <= w_carry_next;
      r_exp_idx <= w_exp_idx_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid     <= 1'b0;
      r_out_vd        <= '0;
      r_out_uop_index <= '0;
      r_out_last      <= 1'b0;
      r_seq_err       <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_seq_err   <= 1'b0;
    end else begin
      r_seq_err <= w_accept && w_seq_mismatch;
      if (w_accept) begin
        r_out_valid     <= 1'b1;
        r_out_vd        <= w_vd;
        r_out_uop_index <= in_uop_index;
        r_out_last      <= in_uop_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_vd        = r_out_vd;
  assign out_uop_index = r_out_uop_index;
  assign out_last      = r_out_last;
  assign seq_err       = r_seq_err;

endmodule

// File: tb/tb_rvv_backend_alu_mask_viota_seq.sv
// Bench for the sequential viota.m stage: hand-computed vector table, directed
// corner sequences and random instructions against a scoreboard queue.
module tb_rvv_backend_alu_mask_viota_seq;

  typedef struct packed {
    logic [1:0]   sew;
    logic [2:0]   idx;
    logic         last;
    logic [8:0]   vl;
    logic         vm;
    logic [31:0]  vs2;
    logic [31:0]  v0;
    logic [255:0] old;
  } uop_t;

  typedef struct packed {
    uop_t         u;
    logic [255:0] exp_vd;
  } vec_t;

  typedef struct packed {
    logic [255:0] vd;
    logic [2:0]   idx;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   in_uop_index;
  logic         in_uop_last;
  logic [1:0]   in_sew;
  logic [8:0]   in_vl;
  logic         in_vm;
  logic [31:0]  in_vs2_mask;
  logic [31:0]  in_v0_mask;
  logic [255:0] in_vd_old;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_vd;
  logic [2:0]   out_uop_index;
  logic         out_last;
  logic         seq_err;

  always #5 clk = ~clk;

  rvv_backend_alu_mask_viota_seq dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_uop_index  (in_uop_index),
    .in_uop_last   (in_uop_last),
    .in_sew        (in_sew),
    .in_vl         (in_vl),
    .in_vm         (in_vm),
    .in_vs2_mask   (in_vs2_mask),
    .in_v0_mask    (in_v0_mask),
    .in_vd_old     (in_vd_old),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_vd        (out_vd),
    .out_uop_index (out_uop_index),
    .out_last      (out_last),
    .seq_err       (seq_err)
  );

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  logic       m_active    = 1'b0;
  logic [8:0] m_carry     = 9'd0;
  logic [2:0] m_exp       = 3'd0;
  logic       m_out_valid = 1'b0;

  logic [255:0] OLD;
  uop_t         idle_u;
  vec_t         tbl [8];

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [255:0] put(input logic [255:0] v, input int w, input int i, input int val);
    logic [31:0] v32;
    v32 = 32'(val);
    for (int b = 0; b < w; b++) v[i*w + b] = v32[b];
    return v;
  endfunction

  // Element-by-element reference: walk the uop, keep a running count of set
  // active mask bits, write carry+count into active slots only.
  function automatic logic [255:0] ref_vd(input uop_t u, input logic [8:0] cin, output logic [8:0] pop);
    int w, e, g;
    logic [8:0] cnt, val;
    logic [31:0] v32;
    logic [255:0] r;
    logic act;
    w = (u.sew == 2'd0) ? 8 : (u.sew == 2'd1) ? 16 : 32;
    e = 256 / w;
    cnt = 9'd0;
    r = u.old;
    for (int i = 0; i < e; i++) begin
      g = int'(u.idx) * e + i;
      act = (g < int'(u.vl)) && (u.vm || u.v0[i]);
      if (act) begin
        val = cin + cnt;
        v32 = 32'(val);
        for (int b = 0; b < w; b++) r[i*w + b] = v32[b];
        if (u.vs2[i]) cnt = cnt + 9'd1;
      end
    end
    pop = cnt;
    return r;
  endfunction

  function automatic uop_t mk(input logic [1:0] sew, input logic [2:0] idx, input logic last,
                              input logic [8:0] vl, input logic vm, input logic [31:0] vs2,
                              input logic [31:0] v0, input logic [255:0] old);
    uop_t u;
    u.sew = sew; u.idx = idx; u.last = last; u.vl = vl; u.vm = vm;
    u.vs2 = vs2; u.v0 = v0; u.old = old;
    return u;
  endfunction

  task automatic drive_cycle(input logic v, input uop_t u, input logic use_exp,
                             input logic [255:0] exp_vd, input logic ordy, input logic fl,
                             output logic acc);
    logic err, exp_rdy;
    logic [8:0] cin, pop;
    exp_t e;
    @(negedge clk);
    in_valid = v; in_uop_index = u.idx; in_uop_last = u.last; in_sew = u.sew;
    in_vl = u.vl; in_vm = u.vm; in_vs2_mask = u.vs2; in_v0_mask = u.v0;
    in_vd_old = u.old; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !fl && (!m_out_valid || ordy);
    chk("in_ready", 256'(in_ready), 256'(exp_rdy));
    chk("out_valid", 256'(out_valid), 256'(m_out_valid));
    acc = v && exp_rdy;
    err = 1'b0;
    if (fl) begin
      m_active = 1'b0; m_carry = 9'd0; m_exp = 3'd0; m_out_valid = 1'b0;
      q.delete();
    end else if (acc) begin
      cin = m_active ? m_carry : 9'd0;
      err = m_active ? (u.idx != m_exp) : (u.idx != 3'd0);
      e.vd = ref_vd(u, cin, pop);
      if (use_exp) e.vd = exp_vd;
      e.idx = u.idx;
      e.last = u.last;
      q.push_back(e);
      if (u.last) begin
        m_active = 1'b0; m_carry = 9'd0; m_exp = 3'd0;
      end else begin
        m_active = 1'b1; m_carry = cin + pop; m_exp = u.idx + 3'd1;
      end
      m_out_valid = 1'b1;
    end else if (ordy) begin
      m_out_valid = 1'b0;
    end
    @(posedge clk);
    #2;
    chk("seq_err", 256'(seq_err), 256'(err));
  endtask

  task automatic send_uop(input uop_t u, input logic use_exp, input logic [255:0] exp_vd,
                          input logic rnd_ready, output int ntries);
    logic acc, ordy;
    ntries = 0;
    acc = 1'b0;
    while (!acc && ntries < 40) begin
      ordy = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive_cycle(1'b1, u, use_exp, exp_vd, ordy, 1'b0, acc);
      ntries++;
    end
    if (!acc) chk("accept_timeout", 256'(0), 256'(1));
  endtask

  task automatic idle(input logic ordy, input logic fl);
    logic acc;
    drive_cycle(1'b0, idle_u, 1'b0, '0, ordy, fl, acc);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 256'(out_valid), 256'(0));
    chk({tag, "_out_vd"}, out_vd, 256'(0));
    chk({tag, "_out_uop_index"}, 256'(out_uop_index), 256'(0));
    chk({tag, "_out_last"}, 256'(out_last), 256'(0));
    chk({tag, "_seq_err"}, 256'(seq_err), 256'(0));
  endtask

  // Scoreboard consumer: sampled just before the edge that completes a handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && !flush && out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", 256'(out_valid), 256'(0));
        end else if (out_ready) begin
          e = q.pop_front();
          chk("out_vd", out_vd, e.vd);
          chk("out_uop_index", 256'(out_uop_index), 256'(e.idx));
          chk("out_last", 256'(out_last), 256'(e.last));
        end else begin
          chk("hold_vd", out_vd, q[0].vd);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nt;
    logic acc;
    uop_t u;
    logic [255:0] x;
    logic [1:0] rs;
    int n, e;
    logic [8:0] rvl;
    logic rvm;

    OLD = {32'h0123_4567, 32'h89AB_CDEF, 32'hFEDC_BA98, 32'h7654_3210,
           32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1357_9BDF, 32'h2468_ACE0};
    idle_u = '0;

    // Hand-computed vectors, applied back to back in order.
    tbl[0].u = mk(2'd0, 3'd0, 1'b0, 9'd40, 1'b1, 32'hFFFF_FFFF, 32'h0, OLD);
    x = OLD; for (int i = 0; i < 32; i++) x = put(x, 8, i, i);
    tbl[0].exp_vd = x;
    tbl[1].u = mk(2'd0, 3'd1, 1'b1, 9'd40, 1'b1, 32'h0000_00FF, 32'h0, OLD);
    x = OLD; for (int i = 0; i < 8; i++) x = put(x, 8, i, 32 + i);
    tbl[1].exp_vd = x;
    tbl[2].u = mk(2'd2, 3'd0, 1'b1, 9'd8, 1'b0, 32'h0000_00FF, 32'h0000_00AA, OLD);
    x = OLD; x = put(x, 32, 1, 0); x = put(x, 32, 3, 1); x = put(x, 32, 5, 2); x = put(x, 32, 7, 3);
    tbl[2].exp_vd = x;
    tbl[3].u = mk(2'd2, 3'd0, 1'b1, 9'd8, 1'b1, 32'h0000_000F, 32'h0, OLD);
    x = OLD; for (int i = 0; i < 8; i++) x = put(x, 32, i, (i < 4) ? i : 4);
    tbl[3].exp_vd = x;
    tbl[4].u = mk(2'd1, 3'd0, 1'b0, 9'd20, 1'b1, 32'h0000_FFFF, 32'h0, OLD);
    x = OLD; for (int i = 0; i < 16; i++) x = put(x, 16, i, i);
    tbl[4].exp_vd = x;
    tbl[5].u = mk(2'd1, 3'd1, 1'b1, 9'd20, 1'b1, 32'h0000_0005, 32'h0, OLD);
    x = OLD; x = put(x, 16, 0, 16); x = put(x, 16, 1, 17); x = put(x, 16, 2, 17); x = put(x, 16, 3, 18);
    tbl[5].exp_vd = x;
    tbl[6].u = mk(2'd0, 3'd0, 1'b0, 9'd0, 1'b1, 32'hFFFF_FFFF, 32'h0, OLD);
    tbl[6].exp_vd = OLD;
    tbl[7].u = mk(2'd0, 3'd1, 1'b1, 9'd64, 1'b1, 32'hFFFF_FFFF, 32'h0, OLD);
    x = OLD; for (int i = 0; i < 32; i++) x = put(x, 8, i, i);
    tbl[7].exp_vd = x;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_uop_index = '0; in_uop_last = 1'b0; in_sew = '0; in_vl = '0; in_vm = 1'b0;
    in_vs2_mask = '0; in_v0_mask = '0; in_vd_old = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) send_uop(tbl[k].u, 1'b1, tbl[k].exp_vd, 1'b0, nt);
    idle(1'b1, 1'b0);

    // Backpressure: 3 stalled cycles with a uop waiting, then full rate.
    send_uop(mk(2'd0, 3'd0, 1'b0, 9'd256, 1'b1, 32'hFFFF_FFFF, 32'h0, OLD), 1'b0, '0, 1'b0, nt);
    u = mk(2'd0, 3'd1, 1'b0, 9'd256, 1'b1, 32'h1234_5678, 32'h0, OLD);
    repeat (3) drive_cycle(1'b1, u, 1'b0, '0, 1'b0, 1'b0, acc);
    for (int k = 1; k < 8; k++) begin
      u = mk(2'd0, 3'(k), (k == 7), 9'd256, 1'b1, $urandom(), 32'h0, OLD);
      send_uop(u, 1'b0, '0, 1'b0, nt);
      chk("throughput_tries", 256'(nt), 256'(1));
    end
    idle(1'b1, 1'b0);

    // Out-of-order index: 0 then 2; seq_err must pulse exactly once.
    send_uop(mk(2'd0, 3'd0, 1'b0, 9'd256, 1'b1, 32'h0000_000F, 32'h0, OLD), 1'b0, '0, 1'b0, nt);
    send_uop(mk(2'd0, 3'd2, 1'b1, 9'd256, 1'b1, 32'h0000_0003, 32'h0, OLD), 1'b0, '0, 1'b0, nt);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);

    // Flush with a result pending mid-instruction.
    send_uop(mk(2'd1, 3'd0, 1'b0, 9'd64, 1'b1, 32'h0000_FFFF, 32'h0, OLD), 1'b0, '0, 1'b0, nt);
    u = mk(2'd1, 3'd1, 1'b0, 9'd64, 1'b1, 32'h0000_00FF, 32'h0, OLD);
    drive_cycle(1'b1, u, 1'b0, '0, 1'b0, 1'b1, acc);
    x = OLD; x = put(x, 16, 0, 0); for (int i = 1; i < 16; i++) x = put(x, 16, i, 1);
    send_uop(mk(2'd1, 3'd0, 1'b1, 9'd64, 1'b1, 32'h0000_0001, 32'h0, OLD), 1'b1, x, 1'b0, nt);
    idle(1'b1, 1'b0);

    // Asynchronous reset while a result and a seq_err pulse are outstanding.
    send_uop(mk(2'd0, 3'd0, 1'b0, 9'd256, 1'b1, 32'hFFFF_FFFF, 32'h0, OLD), 1'b0, '0, 1'b0, nt);
    send_uop(mk(2'd0, 3'd3, 1'b0, 9'd256, 1'b1, 32'h0F0F_0F0F, 32'h0, OLD), 1'b0, '0, 1'b0, nt);
    @(negedge clk);
    #2;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    m_active = 1'b0; m_carry = 9'd0; m_exp = 3'd0; m_out_valid = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_uop(mk(2'd0, 3'd0, 1'b1, 9'd256, 1'b1, 32'hFFFF_FFFF, 32'h0, OLD), 1'b0, '0, 1'b0, nt);
    idle(1'b1, 1'b0);

    // Random instructions with random downstream backpressure.
    for (int t = 0; t < 12; t++) begin
      rs  = 2'($urandom_range(0, 3));
      n   = $urandom_range(1, 8);
      e   = (rs == 2'd0) ? 32 : (rs == 2'd1) ? 16 : 8;
      rvl = 9'($urandom_range(0, n * e));
      rvm = 1'($urandom_range(0, 1));
      for (int k = 0; k < n; k++) begin
        for (int w = 0; w < 8; w++) x[w*32 +: 32] = $urandom();
        u = mk(rs, 3'(k), (k == n - 1), rvl, rvm, $urandom(), $urandom(), x);
        send_uop(u, 1'b0, '0, 1'b1, nt);
      end
    end

    for (int k = 0; k < 20 && q.size() != 0; k++) idle(1'b1, 1'b0);
    chk("drain_empty", 256'(q.size()), 256'(0));
    idle(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
